// File: rtl/deb_pkg.sv
// -----------------------------------------------------------------------------
// deb_pkg
// Shared definitions for the debounce / latch-feeder slice:
//   - FSM state encoding used by debounce_latch_feeder
//   - parameter legality check evaluated at elaboration time
//   - counter width helper so the top derives both counter widths the same way
// -----------------------------------------------------------------------------
package deb_pkg;

    // Controller states. The encodings are fixed so that they stay stable
    // across tools and remain recognisable in waveforms.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_LOAD  = 2'd2
    } deb_state_e;

    // Smallest legal value of each parameter.
    localparam int MIN_SYNC_STAGES     = 2;
    localparam int MIN_DEBOUNCE_CYCLES = 1;
    localparam int MIN_LE_WIDTH        = 1;

    // True when every parameter lies inside its legal range.
    function automatic logic params_legal(
        input int sync_stages,
        input int debounce_cycles,
        input int le_width
    );
        return (sync_stages     >= MIN_SYNC_STAGES)     &&
               (debounce_cycles >= MIN_DEBOUNCE_CYCLES) &&
               (le_width        >= MIN_LE_WIDTH);
    endfunction

    // Width of a counter that has to hold values 0..terminal inclusive.
    function automatic int cnt_width(input int terminal);
        return $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/debounce_latch_feeder_sync.sv
// -----------------------------------------------------------------------------
// sync_ff_chain
// Plain flop-chain synchroniser for one asynchronous bit. Every stage resets
// to 0. A value sampled into stage 0 at edge N is visible on sync_q after
// edge N+STAGES-1.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous, active-high reset (clears the whole chain)
//   din     in   asynchronous input bit
//   sync_q  out  last synchroniser stage
// -----------------------------------------------------------------------------
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync_q
);

    logic [STAGES-1:0] chain_r;

    // Shift the raw input through the chain; reset flushes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_r <= {STAGES{1'b0}};
        end else begin
            chain_r[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
        end
    end

    assign sync_q = chain_r[STAGES-1];

endmodule

// File: rtl/debounce_latch_feeder.sv
// -----------------------------------------------------------------------------
// debounce_latch_feeder
// Conditions a raw switch/pin level before it reaches a level-sensitive D
// latch. The raw input is synchronised and debounced, and every accepted
// level change is presented as a new data bit on d_out together with an
// LE_WIDTH-cycle latch-enable window on le. d_out changes only on the edge
// that opens the window, so it is stable for the whole window and for at
// least DEBOUNCE_CYCLES+1 cycles after it closes.
//
// Parameters
//   SYNC_STAGES      synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES  consecutive mismatch samples required after the first (>= 1)
//   LE_WIDTH         latch-enable high time in clk cycles (>= 1)
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-high reset; overrides everything
//   din_raw       in   asynchronous raw input
//   d_out         out  debounced data, drives the latch d input (registered)
//   le            out  latch enable, LE_WIDTH cycles per accepted change (registered)
//   change_pulse  out  one-cycle pulse on the first le cycle (registered)
//   busy          out  high while the controller is not idle (decoded from state)
// -----------------------------------------------------------------------------
module debounce_latch_feeder
    import deb_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LE_WIDTH        = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din_raw,
    output logic d_out,
    output logic le,
    output logic change_pulse,
    output logic busy
);

    localparam int CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam int LE_CNT_W = cnt_width(LE_WIDTH);

    localparam logic [CNT_W-1:0]    CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_TERM  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [LE_CNT_W-1:0] LE_ZERO   = LE_CNT_W'(0);
    localparam logic [LE_CNT_W-1:0] LE_ONE    = LE_CNT_W'(1);
    localparam logic [LE_CNT_W-1:0] LE_TERM   = LE_CNT_W'(LE_WIDTH);

    // Refuse to elaborate with out-of-range parameters.
    if (!params_legal(SYNC_STAGES, DEBOUNCE_CYCLES, LE_WIDTH)) begin : g_param_check
        $error("debounce_latch_feeder: illegal parameters SYNC_STAGES=%0d DEBOUNCE_CYCLES=%0d LE_WIDTH=%0d",
               SYNC_STAGES, DEBOUNCE_CYCLES, LE_WIDTH);
    end

    logic                sync_q_s;
    deb_state_e          state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [LE_CNT_W-1:0] lecnt_r;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (din_raw),
        .sync_q (sync_q_s)
    );

    // Controller: debounce counting, latch-enable window and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            lecnt_r      <= LE_ZERO;
            d_out        <= 1'b0;
            le           <= 1'b0;
            change_pulse <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    change_pulse <= 1'b0;
                    le           <= 1'b0;
                    lecnt_r      <= LE_ZERO;
                    if (sync_q_s != d_out) begin
                        // The first mismatching sample counts as one.
                        state_r <= ST_COUNT;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                    end
                end

                ST_COUNT: begin
                    change_pulse <= 1'b0;
                    le           <= 1'b0;
                    if (sync_q_s == d_out) begin
                        // Bounce: throw away the partial debounce.
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r < CNT_TERM) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        // Level accepted: new data and the enable window open together.
                        state_r      <= ST_LOAD;
                        cnt_r        <= CNT_ZERO;
                        d_out        <= sync_q_s;
                        le           <= 1'b1;
                        change_pulse <= 1'b1;
                        lecnt_r      <= LE_ONE;
                    end
                end

                ST_LOAD: begin
                    // sync_q is deliberately ignored here; IDLE looks at it again.
                    change_pulse <= 1'b0;
                    if (lecnt_r < LE_TERM) begin
                        lecnt_r <= lecnt_r + LE_ONE;
                        le      <= 1'b1;
                    end else begin
                        lecnt_r <= LE_ZERO;
                        le      <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a quiet idle, keep d_out.
                    state_r      <= ST_IDLE;
                    cnt_r        <= CNT_ZERO;
                    lecnt_r      <= LE_ZERO;
                    le           <= 1'b0;
                    change_pulse <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_debounce_latch_feeder.sv
// -----------------------------------------------------------------------------
// tb_debounce_latch_feeder
// Two instances share one stimulus stream: one with default parameters and one
// with LE_WIDTH=3. Expected outputs come from a window-based reference model:
// a level is accepted at edge e when the synchronised value seen at edges
// e-DEBOUNCE_CYCLES..e all differ from the current data bit and that window
// starts no earlier than the first edge the controller is free to look again.
// -----------------------------------------------------------------------------
module tb_debounce_latch_feeder;

    localparam int SS   = 2;
    localparam int DC   = 4;
    localparam int HMAX = 8192;

    logic clk = 1'b0;
    logic rst;
    logic din_raw;

    logic d_out_a, le_a, cp_a, busy_a;
    logic d_out_b, le_b, cp_b, busy_b;

    always #5 clk = ~clk;

    debounce_latch_feeder #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .LE_WIDTH        (1)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .din_raw      (din_raw),
        .d_out        (d_out_a),
        .le           (le_a),
        .change_pulse (cp_a),
        .busy         (busy_a)
    );

    debounce_latch_feeder #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .LE_WIDTH        (3)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .din_raw      (din_raw),
        .d_out        (d_out_b),
        .le           (le_b),
        .change_pulse (cp_b),
        .busy         (busy_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int   edge_n        = 0;
    int   last_rst_edge = -1000;
    logic raw_hist [0:HMAX-1];
    int   lw        [2] = '{1, 3};
    logic md        [2];
    logic mle       [2];
    logic mcp       [2];
    logic mbusy     [2];
    int   le_first  [2];
    int   le_last   [2];
    int   free_from [2];
    logic exp_latch [2];
    logic dut_latch [2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    // Synchronised value the controller sees at edge e.
    function automatic logic seen(input int e);
        if ((e - SS) <= last_rst_edge || (e - SS) < 0) begin
            return 1'b0;
        end
        return raw_hist[(e - SS) % HMAX];
    endfunction

    task automatic model_edge(input logic r, input logic d);
        logic dprev;
        logic acc;
        if (r) begin
            last_rst_edge = edge_n;
            for (int i = 0; i < 2; i++) begin
                md[i]        = 1'b0;
                mle[i]       = 1'b0;
                mcp[i]       = 1'b0;
                mbusy[i]     = 1'b0;
                le_first[i]  = -100;
                le_last[i]   = -100;
                free_from[i] = edge_n + 1;
            end
        end else begin
            raw_hist[edge_n % HMAX] = d;
            for (int i = 0; i < 2; i++) begin
                dprev = md[i];
                acc   = (edge_n - DC) >= free_from[i];
                for (int j = edge_n - DC; j <= edge_n; j++) begin
                    if (seen(j) == dprev) acc = 1'b0;
                end
                if (acc) begin
                    md[i]        = seen(edge_n);
                    le_first[i]  = edge_n;
                    le_last[i]   = edge_n + lw[i] - 1;
                    free_from[i] = edge_n + lw[i] + 1;
                end
                mle[i]   = (edge_n >= le_first[i]) && (edge_n <= le_last[i]);
                mcp[i]   = (edge_n == le_first[i]);
                mbusy[i] = mle[i] || ((edge_n >= free_from[i]) && (seen(edge_n) != dprev));
                if (mle[i]) exp_latch[i] = md[i];
            end
        end
    endtask

    task automatic step(input logic r, input logic d);
        rst     = r;
        din_raw = d;
        @(posedge clk);
        edge_n++;
        model_edge(r, d);
        #1;
        if (le_a) dut_latch[0] = d_out_a;
        if (le_b) dut_latch[1] = d_out_b;
        check_val("a_d_out", {31'd0, d_out_a}, {31'd0, md[0]});
        check_val("a_le",    {31'd0, le_a},    {31'd0, mle[0]});
        check_val("a_pulse", {31'd0, cp_a},    {31'd0, mcp[0]});
        check_val("a_busy",  {31'd0, busy_a},  {31'd0, mbusy[0]});
        check_val("a_latch", {31'd0, dut_latch[0]}, {31'd0, exp_latch[0]});
        check_val("b_d_out", {31'd0, d_out_b}, {31'd0, md[1]});
        check_val("b_le",    {31'd0, le_b},    {31'd0, mle[1]});
        check_val("b_pulse", {31'd0, cp_b},    {31'd0, mcp[1]});
        check_val("b_busy",  {31'd0, busy_b},  {31'd0, mbusy[1]});
        check_val("b_latch", {31'd0, dut_latch[1]}, {31'd0, exp_latch[1]});
    endtask

    initial begin
        int   run;
        logic v;
        for (int i = 0; i < HMAX; i++) raw_hist[i] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            md[i] = 1'b0; mle[i] = 1'b0; mcp[i] = 1'b0; mbusy[i] = 1'b0;
            le_first[i] = -100; le_last[i] = -100; free_from[i] = 0;
            exp_latch[i] = 1'b0; dut_latch[i] = 1'b0;
        end
        rst     = 1'b1;
        din_raw = 1'b1;

        // Reset held three cycles with the input high
        repeat (3) step(1'b1, 1'b1);

        // Clean rise and fall
        repeat (8)  step(1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b1);
        repeat (12) step(1'b0, 1'b0);

        // Short glitch is rejected
        repeat (3)  step(1'b0, 1'b1);
        repeat (12) step(1'b0, 1'b0);

        // Rise followed by toggling from the load edge onward
        repeat (7) step(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b0, k[0]);
        repeat (12) step(1'b0, 1'b1);
        repeat (12) step(1'b0, 1'b0);

        // Reset in the middle of a debounce, then in the middle of a load
        repeat (4)  step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1);
        repeat (12) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (7)  step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b0);

        // Back-to-back changes
        repeat (7)  step(1'b0, 1'b1);
        repeat (16) step(1'b0, 1'b0);

        // Random level runs with occasional resets
        for (int k = 0; k < 1500; k += run) begin
            v   = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 9);
            for (int j = 0; j < run; j++) begin
                step(($urandom_range(0, 199) == 0), v);
            end
        end
        repeat (16) step(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
